// File: rtl/matvec_pkg.sv
// Shared types and sizing helpers for the streaming matrix-vector engine.
// The state type is shared so checkers can decode the controller state.
package matvec_pkg;

    typedef enum logic [2:0] {
        LOAD_W,
        LOAD_X,
        COMPUTE,
        DRAIN,
        OUT
    } state_t;

    // Output width that cannot overflow when summing n products of two t-bit values.
    function automatic int calc_ow(input int t, input int n);
        return 2 * t + $clog2(n + 1);
    endfunction

    // Index width for an array of 'depth' entries, never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/matvec_stream_mac_pipe.sv
// Signed multiply-accumulate lane: P multiplier stages, a product register and an accumulator.
// The valid/last tags travel with each product so the controller knows when a row sum is final.
module mac_pipe #(
    parameter int T  = 14,
    parameter int P  = 2,
    parameter int OW = 30
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_en,
    input  logic                 i_clear,
    input  logic                 i_valid,
    input  logic                 i_last,
    input  logic signed [T-1:0]  i_a,
    input  logic signed [T-1:0]  i_b,
    output logic signed [OW-1:0] o_acc,
    output logic                 o_last
);

    logic signed [2*T-1:0] r_prod [P+1];
    logic        [P:0]     r_vld;
    logic        [P:0]     r_lst;
    logic signed [OW-1:0]  r_acc;
    logic signed [2*T-1:0] w_mul;
    logic signed [OW-1:0]  w_ext;

    assign w_mul  = i_a * i_b;
    assign w_ext  = r_prod[P];
    assign o_acc  = r_acc;
    assign o_last = i_en & r_vld[P] & r_lst[P];

    // Stage 0..P-1 are the multiplier stages; stage P is the product register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
            r_lst <= '0;
            r_acc <= '0;
        end else begin
            if (i_en) begin
                r_prod[0] <= w_mul;
                r_vld[0]  <= i_valid;
                r_lst[0]  <= i_valid & i_last;
                for (int s = 1; s <= P; s++) begin
                    r_prod[s] <= r_prod[s-1];
                    r_vld[s]  <= r_vld[s-1];
                    r_lst[s]  <= r_lst[s-1];
                end
            end
            if (i_clear) begin
                r_acc <= '0;
            end else if (i_en && r_vld[P]) begin
                r_acc <= r_acc + w_ext;
            end
        end
    end

endmodule

// File: rtl/matvec_stream.sv
// Streaming y = W*x engine: loads W (optional) and x over one input stream, emits M row sums.
// Handshake: a word moves on any cycle where valid && ready; valid holds its data until ready.
module matvec_stream
    import matvec_pkg::*;
#(
    parameter  int M  = 3,
    parameter  int N  = 3,
    parameter  int T  = 14,
    parameter  int P  = 2,
    localparam int OW = calc_ow(T, N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 input_valid,
    output logic                 input_ready,
    input  logic signed [T-1:0]  input_data,
    input  logic                 new_matrix,
    output logic                 output_valid,
    input  logic                 output_ready,
    output logic signed [OW-1:0] output_data
);

    localparam int AW = addr_w(M * N);
    localparam int KW = addr_w(N);
    localparam int RW = addr_w(M);
    localparam logic [AW-1:0] W_LAST = AW'(M * N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);
    localparam logic [RW-1:0] R_LAST = RW'(M - 1);

    logic signed [T-1:0] r_wmem [M*N];
    logic signed [T-1:0] r_xmem [N];

    state_t          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_mat_loaded;
    logic [AW-1:0]   r_widx;
    logic [KW-1:0]   r_xidx;
    logic [AW-1:0]   r_raddr;
    logic [KW-1:0]   r_k;
    logic [RW-1:0]   r_row;
    logic            r_rd_valid;
    logic            r_rd_last;
    logic signed [T-1:0] r_rd_w;
    logic signed [T-1:0] r_rd_x;

    logic w_xfer, w_vec_first, w_we_w, w_we_x, w_out_fire, w_acc_last;

    assign input_ready  = r_in_ready & ~reset;
    assign output_valid = r_out_valid & ~reset;
    assign w_xfer       = input_valid & input_ready;
    assign w_out_fire   = output_valid & output_ready;

    // A vector-only job is recognised on its first word, and only once a matrix is held.
    assign w_vec_first = (r_state == LOAD_W) && (r_widx == '0) && !new_matrix && r_mat_loaded;
    assign w_we_w      = w_xfer && (r_state == LOAD_W) && !w_vec_first;
    assign w_we_x      = w_xfer && ((r_state == LOAD_X) || w_vec_first);

    always_ff @(posedge clk) begin
        if (w_we_w) r_wmem[r_widx] <= input_data;
        if (w_we_x) r_xmem[r_xidx] <= input_data;
        r_rd_w <= r_wmem[r_raddr];
        r_rd_x <= r_xmem[r_k];
    end

    mac_pipe #(.T(T), .P(P), .OW(OW)) u_mac (
        .clk     (clk),
        .reset   (reset),
        .i_en    (r_state != OUT),
        .i_clear (w_out_fire),
        .i_valid (r_rd_valid),
        .i_last  (r_rd_last),
        .i_a     (r_rd_w),
        .i_b     (r_rd_x),
        .o_acc   (output_data),
        .o_last  (w_acc_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= LOAD_W;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_mat_loaded <= 1'b0;
            r_widx       <= '0;
            r_xidx       <= '0;
            r_raddr      <= '0;
            r_k          <= '0;
            r_row        <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
        end else begin
            r_rd_valid <= (r_state == COMPUTE);
            r_rd_last  <= (r_state == COMPUTE) && (r_k == K_LAST);
            case (r_state)
                LOAD_W: begin
                    if (w_we_w) begin
                        if (r_widx == W_LAST) begin
                            r_widx  <= '0;
                            r_state <= LOAD_X;
                        end else begin
                            r_widx <= r_widx + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    r_raddr <= r_raddr + 1'b1;
                    if (r_k == K_LAST) begin
                        r_k     <= '0;
                        r_state <= DRAIN;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_acc_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end
                end
                OUT: begin
                    if (output_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_row == R_LAST) begin
                            r_row      <= '0;
                            r_in_ready <= 1'b1;
                            r_state    <= LOAD_W;
                        end else begin
                            r_row   <= r_row + 1'b1;
                            r_state <= COMPUTE;
                        end
                    end
                end
                default: ;
            endcase
            // Vector writes come from LOAD_X or from the first word of a vector-only job.
            if (w_we_x) begin
                if (r_xidx == K_LAST) begin
                    r_xidx       <= '0;
                    r_mat_loaded <= 1'b1;
                    r_in_ready   <= 1'b0;
                    r_raddr      <= '0;
                    r_k          <= '0;
                    r_row        <= '0;
                    r_state      <= COMPUTE;
                end else begin
                    r_xidx  <= r_xidx + 1'b1;
                    r_state <= LOAD_X;
                end
            end
        end
    end

endmodule

// File: tb/tb_matvec_stream.sv
// Bench for matvec_stream: directed 3x3 jobs from a vector table plus a randomized 4x5 run
// scored against a plain-arithmetic reference model.
module tb_matvec_stream;

    localparam int OWA = 30;
    localparam int OWB = 31;

    logic clk = 1'b0;
    logic a_reset, b_reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic                   a_iv, a_ir, a_nm, a_ov, a_or;
    logic        [13:0]     a_id;
    logic signed [OWA-1:0]  a_od;
    logic                   b_iv, b_ir, b_nm, b_ov, b_or;
    logic        [13:0]     b_id;
    logic signed [OWB-1:0]  b_od;

    matvec_stream #(.M(3), .N(3), .T(14), .P(2)) u_dut_a (
        .clk(clk), .reset(a_reset), .input_valid(a_iv), .input_ready(a_ir),
        .input_data(a_id), .new_matrix(a_nm), .output_valid(a_ov),
        .output_ready(a_or), .output_data(a_od)
    );

    matvec_stream #(.M(4), .N(5), .T(14), .P(0)) u_dut_b (
        .clk(clk), .reset(b_reset), .input_valid(b_iv), .input_ready(b_ir),
        .input_data(b_id), .new_matrix(b_nm), .output_valid(b_ov),
        .output_ready(b_or), .output_data(b_od)
    );

    typedef struct packed {
        logic             nm;
        logic             send_w;
        logic [8:0][13:0] w;
        logic [2:0][13:0] x;
        logic [2:0][29:0] y;
    } vec_t;

    vec_t tbl [5];
    int   w3 [9] = '{3, -2, 5, 0, 7, -1, -4, 4, 4};
    int   last_rdy_cyc;

    logic [OWB-1:0] exp_q [$];
    int   b_in_cnt = 0, b_out_cnt = 0, b_exp_in = 0;

    always @(posedge clk) begin
        if (b_iv && b_ir) b_in_cnt <= b_in_cnt + 1;
        if (b_ov && b_or) b_out_cnt <= b_out_cnt + 1;
    end

    initial begin
        #(900000);
        $display("FAIL watchdog: simulation did not finish, cycle %0d required < 90000", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_a(input logic [13:0] d, input logic nm);
        int n = 0;
        @(negedge clk);
        a_iv = 1'b1; a_id = d; a_nm = nm;
        while (!a_ir && n < 200) begin @(negedge clk); n++; end
        if (!a_ir) begin
            check("a_ready_timeout", 0, 1);
            a_iv = 1'b0;
        end else begin
            last_rdy_cyc = cyc;
            @(posedge clk);
        end
    endtask

    task automatic collect_a(input vec_t v, input int bp_row, input int first_cyc);
        int n, prev_cyc;
        prev_cyc = 0;
        for (int r = 0; r < 3; r++) begin
            a_or = (r == bp_row) ? 1'b0 : 1'b1;
            n = 0;
            while (!a_ov && n < 200) begin @(negedge clk); n++; end
            if (!a_ov) begin
                check("a_valid_timeout", 0, 1);
                a_or = 1'b1;
                return;
            end
            if (r == 0) check("a_first_latency", cyc, first_cyc);
            if (r == 1 && bp_row < 0) check("a_row_gap", cyc - prev_cyc, 8);
            if (r == bp_row) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    check("a_bp_valid", a_ov, 1);
                    check("a_bp_data", a_od, $signed(v.y[r]));
                end
                a_or = 1'b1;
            end
            check("a_row", a_od, $signed(v.y[r]));
            prev_cyc = cyc;
            @(negedge clk);
        end
    endtask

    task automatic run_a(input vec_t v, input int bp_row);
        if (v.send_w) for (int i = 0; i < 9; i++) send_a(v.w[i], v.nm);
        for (int i = 0; i < 3; i++) send_a(v.x[i], v.nm);
        @(negedge clk);
        a_iv = 1'b0;
        check("a_ready_drop", a_ir, 0);
        collect_a(v, bp_row, last_rdy_cyc + 1 + 7);
    endtask

    task automatic send_b(input logic [13:0] d, input logic nm);
        int n = 0;
        @(negedge clk);
        while ($urandom_range(0, 2) == 0) begin b_iv = 1'b0; @(negedge clk); end
        b_iv = 1'b1; b_id = d; b_nm = nm;
        while (!b_ir && n < 2000) begin @(negedge clk); n++; end
        if (!b_ir) begin
            check("b_ready_timeout", 0, 1);
            b_iv = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic producer_b();
        logic signed [13:0] bw [20];
        logic signed [13:0] bx [5];
        logic loaded, nm, full;
        longint y;
        loaded = 1'b0;
        for (int j = 0; j < 200; j++) begin
            nm   = 1'($urandom_range(0, 1));
            full = nm || !loaded;
            if (full) for (int i = 0; i < 20; i++) bw[i] = 14'($urandom_range(0, 16383));
            for (int i = 0; i < 5; i++) bx[i] = 14'($urandom_range(0, 16383));
            loaded = 1'b1;
            for (int r = 0; r < 4; r++) begin
                y = 0;
                for (int k = 0; k < 5; k++) y += longint'(bw[r*5+k]) * longint'(bx[k]);
                exp_q.push_back(OWB'(y));
            end
            b_exp_in += full ? 25 : 5;
            if (full) for (int i = 0; i < 20; i++) send_b(bw[i], nm);
            for (int i = 0; i < 5; i++) send_b(bx[i], nm);
        end
        @(negedge clk);
        b_iv = 1'b0;
    endtask

    task automatic consumer_b();
        int got = 0, idle = 0;
        logic [OWB-1:0] e;
        while (got < 800 && idle < 5000) begin
            @(negedge clk);
            b_or = 1'($urandom_range(0, 1));
            if (b_ov && b_or) begin
                if (exp_q.size() == 0) begin
                    check("b_unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("b_row", b_od, $signed(e));
                end
                got++;
                idle = 0;
            end else begin
                idle++;
            end
        end
        if (got < 800) check("b_output_timeout", got, 800);
        @(negedge clk);
        b_or = 1'b0;
    endtask

    initial begin
        int n, bad;
        a_reset = 1'b1; b_reset = 1'b1;
        a_iv = 1'b0; a_id = '0; a_nm = 1'b0; a_or = 1'b1;
        b_iv = 1'b0; b_id = '0; b_nm = 1'b0; b_or = 1'b0;

        for (int i = 0; i < 9; i++) tbl[0].w[i] = 14'(i + 1);
        tbl[0].nm = 1'b1; tbl[0].send_w = 1'b1;
        tbl[0].x = {14'd3, 14'd2, 14'd1};
        tbl[0].y = {30'd50, 30'd32, 30'd14};
        tbl[1] = tbl[0];
        tbl[1].nm = 1'b0; tbl[1].send_w = 1'b0;
        tbl[1].x = {14'd1, 14'd0, -14'sd1};
        tbl[1].y = {30'd2, 30'd2, 30'd2};
        for (int i = 0; i < 9; i++) tbl[2].w[i] = -14'sd8192;
        tbl[2].nm = 1'b1; tbl[2].send_w = 1'b1;
        tbl[2].x = {-14'sd8192, -14'sd8192, -14'sd8192};
        tbl[2].y = {30'd201326592, 30'd201326592, 30'd201326592};
        for (int i = 0; i < 9; i++) tbl[3].w[i] = 14'(w3[i]);
        tbl[3].nm = 1'b1; tbl[3].send_w = 1'b1;
        tbl[3].x = {14'd2, -14'sd6, 14'd10};
        tbl[3].y = {-30'sd56, -30'sd44, 30'd52};
        for (int i = 0; i < 9; i++) tbl[4].w[i] = (i % 4 == 0) ? 14'd1 : 14'd0;
        tbl[4].nm = 1'b0; tbl[4].send_w = 1'b1;
        tbl[4].x = {14'd6, 14'd5, 14'd4};
        tbl[4].y = {30'd6, 30'd5, 30'd4};

        repeat (3) @(negedge clk);
        check("reset_ready_low", a_ir, 0);
        a_reset = 1'b0; b_reset = 1'b0;
        #1;
        check("reset_ready", a_ir, 1);
        check("reset_valid", a_ov, 0);
        check("reset_data", a_od, 0);
        check("reset_b_ready", b_ir, 1);

        for (int j = 0; j < 4; j++) run_a(tbl[j], -1);
        run_a(tbl[0], 1);

        for (int i = 0; i < 9; i++) send_a(tbl[0].w[i], 1'b1);
        for (int i = 0; i < 3; i++) send_a(tbl[0].x[i], 1'b1);
        @(negedge clk);
        a_iv = 1'b0;
        n = 0;
        while (!a_ov && n < 200) begin @(negedge clk); n++; end
        check("abort_row0", a_od, 14);
        @(negedge clk);
        repeat (4) @(negedge clk);
        a_reset = 1'b1;
        #1;
        check("abort_ready_low", a_ir, 0);
        check("abort_valid_low", a_ov, 0);
        @(negedge clk);
        a_reset = 1'b0;
        #1;
        check("abort_ready", a_ir, 1);
        check("abort_valid", a_ov, 0);
        check("abort_data", a_od, 0);
        bad = 0;
        repeat (20) begin @(negedge clk); if (a_ov) bad++; end
        check("abort_silent", bad, 0);
        run_a(tbl[4], -1);

        fork
            producer_b();
            consumer_b();
        join
        repeat (3) @(negedge clk);
        check("b_in_handshakes", b_in_cnt, b_exp_in);
        check("b_out_handshakes", b_out_cnt, 800);
        check("b_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matvec_stream.md
Name: matvec_stream

Overview:
- Parametrised successor to the fixed 3x3 matrix-vector engine. Computes y = W·x for a signed M×N matrix W and an N-vector x, all streamed in on one valid/ready input.
- Results leave as M signed words on a valid/ready output stream with full backpressure.
- Adds matrix reuse: a job may carry only a new vector and keep the stored matrix.
- Adds a configurable multiplier pipeline depth.

Parameters:
- M, 3, matrix rows / output words per job (>=1).
- N, 3, matrix columns / vector length (>=1).
- T, 14, input data width, signed.
- P, 2, multiplier pipeline register stages (>=0).
- OW, 2*T+$clog2(N+1), output width (localparam, overflow-free).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- input_valid  in  1  input word valid.
- input_ready  out  1  block accepts input word.
- input_data  in  T  signed input word.
- new_matrix  in  1  sampled with the first word of a job; 1 = job begins with M*N matrix words, 0 = job is N vector words only.
- output_valid  out  1  output word valid.
- output_ready  in  1  consumer accepts output word.
- output_data  out  OW  signed row result.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: input_ready=0 during the reset cycle, then 1 (state LOAD_W); output_valid=0; output_data=0; all counters 0; matrix_loaded=0.
- Reset does not clear the storage arrays.
- Input transfer occurs on a cycle with input_valid && input_ready. input_ready=1 only in LOAD_W and LOAD_X.
- States:
  - LOAD_W: first transfer of a job samples new_matrix.
    - If new_matrix=1, or matrix_loaded=0 (forced load): write word to W[0] row-major and continue filling W over M*N transfers, then go to LOAD_X.
    - If new_matrix=0 and matrix_loaded=1: the first word goes to x[0], go to LOAD_X.
  - LOAD_X: write x[0..N-1]. On the N-th transfer: set matrix_loaded=1, input_ready=0 next cycle, go to COMPUTE with row=0.
  - COMPUTE: issue N synchronous reads of W[row][k], x[k] on consecutive cycles, k=0..N-1, one per cycle, no bubbles. Then enter DRAIN.
  - DRAIN: wait for the pipeline. output_valid rises exactly N+P+2 cycles after the cycle the k=0 read address was issued (1 read + P mult + 1 product reg + accumulate).
  - OUT: output_valid=1. output_data holds the accumulated row sum and stays stable until the handshake.
    - On output_valid && output_ready: clear the accumulator.
    - If row<M-1: row++ and go to COMPUTE on the next cycle; output_valid=0 for at least N+P+1 cycles.
    - If row=M-1: go to LOAD_W; input_ready=1 on the next cycle.
- Gaps in input_valid insert idle cycles only; the word order is unaffected.
- Output stall: no new reads, accumulations or multiplier advances while in OUT. The pipeline is empty in OUT by construction.
- Arithmetic: full-precision signed T×T product, sign-extended to OW before accumulation; no saturation.
- The accumulator is cleared at the handshake, never implicitly on reset-free state transitions.
- Reset mid-operation (any state): return to the reset values on the next cycle. The partial job is discarded and no output is emitted for it. matrix_loaded=0, so the next job performs a matrix load regardless of new_matrix.
- M=1 or N=1 are legal. N=1 gives a single read per row.
- output_ready held high gives back-to-back rows with the latency above.

Decomposition:
- Package matvec_pkg: state enum {LOAD_W, LOAD_X, COMPUTE, DRAIN, OUT}; function computing OW from T,N; address-width localparam helpers ($clog2(M*N), $clog2(N)).
- Sub-module mac_pipe #(T,P,OW): P-stage signed multiplier, product register, accumulator with en/clear. Reused by later multi-lane variants.
- The controller FSM and the two storage arrays stay in matvec_stream.

Test Plan:
- M=N=3, P=2, new_matrix=1, W=1..9 row-major, x=1,2,3, output_ready=1 → outputs 14, 32, 50. The first output_valid occurs N+P+2=7 cycles after COMPUTE start.
- Follow-up job, new_matrix=0, x=-1,0,1 (3 transfers only) → outputs 2, 2, 2. input_ready drops after the 3rd word.
- Backpressure: hold output_ready=0 for 5 cycles on row 1 → output_valid stays 1, output_data stays 32, no later row appears early. Release → 50 follows.
- Extremes: T=14, all W and x = -8192 → each output 3·2^26 = 201326592, no overflow in OW=30 bits.
- Reset asserted for 1 cycle mid-DRAIN of row 1 → no output for the aborted job. Next job sent with new_matrix=0 is treated as a matrix load; W=identity, x=4,5,6 → outputs 4, 5, 6.
- Random input_valid gaps and random output_ready, 200 jobs mixing new_matrix=0/1, M=4, N=5, P=0 → all results match the reference model; handshake counts are exactly M*N+N or N per job in and M per job out.
